// File: rtl/ex_mem_pipe_buffer_if.sv
// EX -> MEM stage boundary bundle: the EX-side offer, the MEM-side head view,
// flush and occupancy. The buffer uses the slave view; the stage driving it
// uses the master view.
interface ex_mem_pipe_buffer_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_branch;
    logic                  in_mem_read;
    logic                  in_mem_write;
    logic                  in_reg_write;
    logic                  in_mem_to_reg;
    logic                  in_zero;
    logic [DATA_W-1:0]     in_store_data;
    logic [DATA_W-1:0]     in_alu_out;
    logic [DATA_W-1:0]     in_branch_target;
    logic [REG_ADDR_W-1:0] in_write_reg;

    logic                  out_valid;
    logic                  out_ready;
    logic                  out_branch;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic                  out_reg_write;
    logic                  out_mem_to_reg;
    logic                  out_zero;
    logic [DATA_W-1:0]     out_store_data;
    logic [DATA_W-1:0]     out_alu_out;
    logic [DATA_W-1:0]     out_branch_target;
    logic [REG_ADDR_W-1:0] out_write_reg;

    logic [CNT_W-1:0]      count;

    modport slave (
        input  flush, in_valid, in_branch, in_mem_read, in_mem_write,
               in_reg_write, in_mem_to_reg, in_zero, in_store_data,
               in_alu_out, in_branch_target, in_write_reg, out_ready,
        output in_ready, out_valid, out_branch, out_mem_read, out_mem_write,
               out_reg_write, out_mem_to_reg, out_zero, out_store_data,
               out_alu_out, out_branch_target, out_write_reg, count
    );

    modport master (
        output flush, in_valid, in_branch, in_mem_read, in_mem_write,
               in_reg_write, in_mem_to_reg, in_zero, in_store_data,
               in_alu_out, in_branch_target, in_write_reg, out_ready,
        input  in_ready, out_valid, out_branch, out_mem_read, out_mem_write,
               out_reg_write, out_mem_to_reg, out_zero, out_store_data,
               out_alu_out, out_branch_target, out_write_reg, count
    );
endinterface

// File: rtl/ex_mem_pipe_buffer.sv
// EX -> MEM pipeline boundary implemented as a small in-order circular queue
// with valid/ready on both sides, so a stalled MEM stage back-pressures EX
// instead of dropping instructions. Control outputs are gated by out_valid so
// an empty queue looks like a bubble to MEM.
module ex_mem_pipe_buffer #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
) (
    input logic               clk,
    input logic               rst,
    ex_mem_pipe_buffer_if.slave bus
);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = 6 + 3 * DATA_W + REG_ADDR_W;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wp;
    logic [PTR_W-1:0]   r_rp;
    logic [CNT_W-1:0]   r_count;

    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_head;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_wp_next;
    logic [PTR_W-1:0]   w_rp_next;

    logic                  w_h_branch;
    logic                  w_h_mem_read;
    logic                  w_h_mem_write;
    logic                  w_h_reg_write;
    logic                  w_h_mem_to_reg;
    logic                  w_h_zero;
    logic [DATA_W-1:0]     w_h_store_data;
    logic [DATA_W-1:0]     w_h_alu_out;
    logic [DATA_W-1:0]     w_h_branch_target;
    logic [REG_ADDR_W-1:0] w_h_write_reg;

    assign w_in_entry = {bus.in_branch, bus.in_mem_read, bus.in_mem_write,
                         bus.in_reg_write, bus.in_mem_to_reg, bus.in_zero,
                         bus.in_store_data, bus.in_alu_out,
                         bus.in_branch_target, bus.in_write_reg};

    // Readiness comes only from the registered occupancy, so a full queue
    // refuses an offer even on a cycle where MEM pops the head.
    assign w_in_ready  = (r_count < FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
    assign w_wp_next = (r_wp == LAST_PTR) ? '0 : r_wp + PTR_W'(1);
    assign w_rp_next = (r_rp == LAST_PTR) ? '0 : r_rp + PTR_W'(1);

    // Queue state: reset clears everything, flush only rewinds the pointers,
    // otherwise push/pop. Updates on the falling edge like the other stage
    // registers of the pipeline.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_in_entry;
                r_wp        <= w_wp_next;
            end
            if (w_pop) begin
                r_rp <= w_rp_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - ONE_CNT;
            end
        end
    end

    assign w_head = r_mem[r_rp];
    assign {w_h_branch, w_h_mem_read, w_h_mem_write, w_h_reg_write,
            w_h_mem_to_reg, w_h_zero, w_h_store_data, w_h_alu_out,
            w_h_branch_target, w_h_write_reg} = w_head;

    assign bus.in_ready          = w_in_ready;
    assign bus.out_valid         = w_out_valid;
    assign bus.count             = r_count;

    // Control bits are masked when empty so MEM sees a harmless bubble;
    // data fields simply show whatever the head slot last held.
    assign bus.out_branch        = w_h_branch     & w_out_valid;
    assign bus.out_mem_read      = w_h_mem_read   & w_out_valid;
    assign bus.out_mem_write     = w_h_mem_write  & w_out_valid;
    assign bus.out_reg_write     = w_h_reg_write  & w_out_valid;
    assign bus.out_mem_to_reg    = w_h_mem_to_reg & w_out_valid;
    assign bus.out_zero          = w_h_zero       & w_out_valid;
    assign bus.out_store_data    = w_h_store_data;
    assign bus.out_alu_out       = w_h_alu_out;
    assign bus.out_branch_target = w_h_branch_target;
    assign bus.out_write_reg     = w_h_write_reg;
endmodule
